// File: rtl/mod_inv_bin.sv
// mod_inv_bin: modular inverse a^-1 mod m, binary extended Euclid.
// Multi-cycle, one op in flight; run-time odd modulus m.
// Ports:
//   clk        rising-edge clock
//   reset      async active-high reset
//   start      request, sampled only when busy=0
//   input_num  operand a (WIDTH)
//   modulus    odd modulus m (WIDTH)
//   inverse    a^-1 mod m while done=1 and error=0, else 0
//   done       result/status valid, held until next start
//   busy       computation in progress
//   error      invalid operand or gcd(a,m)!=1 (with done)
// Build option: MOD_INV_BIN_TIMEOUT_EN adds an ITER cycle
// watchdog that forces error after 4*WIDTH+1 cycles.
module mod_inv_bin #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input_num,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] inverse,
  output logic             done,
  output logic             busy,
  output logic             error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_ITER   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] x2_q, x2_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             tmo;

`ifdef MOD_INV_BIN_TIMEOUT_EN
  localparam int CW = $clog2(4 * WIDTH) + 1;
  localparam logic [CW-1:0] CMAX = CW'(4 * WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of ITER cycles already spent, so
  // the (4*WIDTH+1)-th ITER cycle sees cnt_q == CMAX.
  assign tmo = (cnt_q == CMAX);
`else
  assign tmo = 1'b0;
`endif

  // Datapath: every add/sub/compare is WIDTH+1 bits so the
  // carry/borrow is visible.
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   x1_sum, x2_sum;
  logic [WIDTH-1:0] x1_half, x2_half;
  logic [WIDTH:0]   x12_diff, x21_diff;
  logic [WIDTH:0]   x12_adj, x21_adj;
  logic [WIDTH-1:0] x12_fix, x21_fix;
  logic [WIDTH:0]   uv_diff, vu_diff;
  logic             u_ge_v;

  assign m_ext = {1'b0, m_q};

  // Halving mod m: odd x gets m added first so the sum is even.
  assign x1_sum  = {1'b0, x1_q} + m_ext;
  assign x2_sum  = {1'b0, x2_q} + m_ext;
  assign x1_half = x1_q[0] ? x1_sum[WIDTH:1] : (x1_q >> 1);
  assign x2_half = x2_q[0] ? x2_sum[WIDTH:1] : (x2_q >> 1);

  // Subtraction mod m: add m back when the difference borrows.
  // The corrected value lies in [0,m), so the top bit drops.
  assign x12_diff = {1'b0, x1_q} - {1'b0, x2_q};
  assign x21_diff = {1'b0, x2_q} - {1'b0, x1_q};
  assign x12_adj  = x12_diff + m_ext;
  assign x21_adj  = x21_diff + m_ext;
  assign x12_fix  = x12_diff[WIDTH] ? x12_adj[WIDTH-1:0]
                                    : x12_diff[WIDTH-1:0];
  assign x21_fix  = x21_diff[WIDTH] ? x21_adj[WIDTH-1:0]
                                    : x21_diff[WIDTH-1:0];

  assign uv_diff = {1'b0, u_q} - {1'b0, v_q};
  assign vu_diff = {1'b0, v_q} - {1'b0, u_q};
  assign u_ge_v  = ~uv_diff[WIDTH];

  // Operand checks; u_q holds a and m_q holds m in CHECK.
  logic m_bad, a_zero, a_ge_m, a_one;
  logic [WIDTH:0] am_diff;

  assign am_diff = {1'b0, u_q} - m_ext;
  assign m_bad   = ~m_q[0] | (m_q < THREE);
  assign a_zero  = (u_q == '0);
  assign a_ge_m  = ~am_diff[WIDTH];
  assign a_one   = (u_q == ONE);

  logic             fin;
  logic             fin_err;
  logic [WIDTH-1:0] fin_val;

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    m_d     = m_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    inv_d   = inv_q;
    done_d  = done_q;
    busy_d  = busy_q;
    err_d   = err_q;
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_val = '0;
`ifdef MOD_INV_BIN_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          u_d     = input_num;
          v_d     = modulus;
          m_d     = modulus;
          inv_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
`ifdef MOD_INV_BIN_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (m_bad || a_zero || a_ge_m) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (a_one) begin
          fin     = 1'b1;
          fin_val = ONE;
        end else begin
          // v_q already holds m from the start latch.
          x1_d    = ONE;
          x2_d    = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
`ifdef MOD_INV_BIN_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // Ordered rules: first match wins.
        if (u_q == ONE) begin
          fin     = 1'b1;
          fin_val = x1_q;
        end else if (v_q == ONE) begin
          fin     = 1'b1;
          fin_val = x2_q;
        end else if (u_q == '0) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (tmo) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (~u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = x1_half;
        end else if (~v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = x2_half;
        end else if (u_ge_v) begin
          u_d  = uv_diff[WIDTH-1:0];
          x1_d = x12_fix;
        end else begin
          v_d  = vu_diff[WIDTH-1:0];
          x2_d = x21_fix;
        end
      end

      S_FINISH: begin
        // done rose on the edge into this state; a start seen
        // here is deliberately dropped.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are only updated on the edge into FINISH.
    if (fin) begin
      state_d = S_FINISH;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      err_d   = fin_err;
      inv_d   = fin_err ? '0 : fin_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      u_q     <= '0;
      v_q     <= '0;
      m_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      inv_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      m_q     <= m_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

`ifdef MOD_INV_BIN_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign inverse = inv_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign error   = err_q;

endmodule

// File: doc/mod_inv_bin.md
# mod_inv_bin

Parametrised modular inverter for the secp256k1 arithmetic path: computes input_num⁻¹ mod modulus with the binary extended Euclidean algorithm.
- Modulus is a run-time input, so one instance serves both field-prime (p) and group-order (n) inversions; WIDTH is generic.
- Sits between the point-arithmetic sequencer and the projective-to-affine conversion.
- Adds what the fixed 256-bit inverter lacks: operand validation, non-invertible detection, busy/error status and a bounded, known latency.

## Interface
- WIDTH, 256, operand/modulus width in bits (≥ 4)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- input_num  input  WIDTH  value a to invert; sampled with start
- modulus  input  WIDTH  odd modulus m; sampled with start
- inverse  output  WIDTH  a⁻¹ mod m; valid while done=1 and error=0, else 0
- done  output  1  result/status valid; held until next accepted start or reset
- busy  output  1  computation in progress
- error  output  1  invalid operand or gcd(a,m)≠1; qualified by done

## Operation
- States: IDLE, CHECK, ITER, FINISH.
- Reset: all outputs 0; state IDLE.
- IDLE:
  - start=1 latches a=input_num and m=modulus.
  - Clears done, error and inverse; sets busy; goes to CHECK.
  - While busy=1, start is ignored.
- CHECK (1 cycle), error conditions:
  - m even, m < 3, a = 0, or a ≥ m → error=1, go to FINISH.
  - a = 1 → result 1, go to FINISH.
  - Otherwise initialise u=a, v=m, x1=1, x2=0; go to ITER.
- ITER, one action per cycle, first matching rule wins:
  1. u==1 → result x1, go to FINISH.
  2. v==1 → result x2, go to FINISH.
  3. u==0 → error (non-invertible), go to FINISH.
  4. u even → u>>=1; x1 = x1 even ? x1>>1 : (x1+m)>>1, with x1+m computed in WIDTH+1 bits.
  5. v even → same on v/x2.
  6. u≥v → u-=v; x1 = x1-x2, plus m if it borrows.
  7. else → v-=u; x2 = x2-x1, plus m if it borrows.
- Invariant: x1, x2 ∈ [0, m) at all times, so the result needs no final reduction.
- FINISH (1 cycle):
  - Drives inverse (0 on error), done=1, busy=0; returns to IDLE.
  - A start in the same cycle as done rising is ignored.
  - start is accepted from the following cycle.

## Timing
- CHECK-path latency: start cycle T → done=1 at T+2.
- Iterative-path latency: T+2+k, where k = number of ITER cycles.
  - Bound: k ≤ 4·WIDTH. Each halving shrinks bitlen(u)+bitlen(v) by ≥1, and every subtraction is followed by a halving.
- done, error and inverse change only on the FINISH edge or on reset/accepted start.
- Reset asserted mid-operation: outputs 0 and state IDLE immediately (asynchronous); no partial result is ever exposed.
- The subtract, add and compare paths are WIDTH+1 bits wide.
- There is no throughput overlap: one operation is in flight at a time.

## Configuration
- MOD_INV_BIN_TIMEOUT_EN
  - Defined: a counter of width clog2(4·WIDTH)+1 counts ITER cycles. Reaching 4·WIDTH+1 forces error=1 and FINISH, as a safety net against corrupted state.
  - Undefined: no counter; ITER runs until rule 1, 2 or 3 fires.
  - Functional results on valid inputs are identical in both builds.

## Test plan
- WIDTH=8, m=97, a=5 → done with error=0, inverse=39 (0x27); busy high from T+1 until done.
- WIDTH=256, m=secp256k1 p (FFFFFFFF×6 words, FFFFFFFE, FFFFFC2F), a=2 → inverse=7FFFFFFF, FFFFFFFF×6, 7FFFFE18; a=1 → inverse=1 at T+2; done within T+2+1024.
- Invalid operands, WIDTH=8: m=96 (even), a=0, and a=97 with m=97 → each error=1, inverse=0, done at T+2.
- WIDTH=8, m=15, a=6 (gcd 3) → error=1, inverse=0; start pulses during busy are ignored (busy stays high, result unchanged).
- Assert reset mid-ITER → done=busy=error=0 and inverse=0 immediately; a fresh start with m=97, a=5 then yields 39.
- Random sweep, WIDTH=16 with prime m, against a scoreboard (a·inverse mod m = 1). With MOD_INV_BIN_TIMEOUT_EN defined, no timeout error occurs and the ITER count is ≤ 64.
